// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: per-stage enables/flushes for
// load-use, taken branches, multi-cycle EX ops and data-memory waits, plus a stall counter.
module pipeline_ctrl #(
  parameter int unsigned MC_CYCLES   = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_en,
  input  logic                   rst,
  input  logic [4:0]             i_id_rs1,
  input  logic [4:0]             i_id_rs2,
  input  logic                   i_id_uses_rs1,
  input  logic                   i_id_uses_rs2,
  input  logic [4:0]             i_ex_rd,
  input  logic                   i_ex_is_load,
  input  logic                   i_ex_multicycle,
  input  logic                   i_ex_branch_taken,
  input  logic                   i_mem_req,
  input  logic                   i_mem_ready,
  output logic                   o_pc_en,
  output logic                   o_if_id_en,
  output logic                   o_id_ex_en,
  output logic                   o_ex_mem_en,
  output logic                   o_mem_wb_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic                   o_ex_mem_flush,
  output logic                   o_busy,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned McW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [McW-1:0] McLast = McW'(MC_CYCLES - 1);

  typedef enum logic {StRun, StMcBusy} state_e;

  state_e                 r_state, w_state_nxt;
  logic [McW-1:0]         r_mc_cnt, w_mc_cnt_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_mem_stall, w_load_use;
  logic [7:0] w_ctl;  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl}

  localparam logic [7:0] CtlDefault = 8'b11111_000;
  localparam logic [7:0] CtlBubble  = 8'b00011_001;
  localparam logic [7:0] CtlBranch  = 8'b11111_110;
  localparam logic [7:0] CtlLoadUse = 8'b00111_010;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_load_use  = i_ex_is_load & (i_ex_rd != 5'd0) &
                       ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                        (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    w_ctl        = CtlDefault;
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    if (!rst) begin
      w_ctl = '0;
    end else if (w_mem_stall) begin
      w_ctl = '0;
    end else if (r_state == StMcBusy) begin
      if (r_mc_cnt != McLast) begin
        w_ctl        = CtlBubble;
        w_mc_cnt_nxt = r_mc_cnt + 1'b1;
      end else begin
        w_state_nxt  = StRun;
        w_mc_cnt_nxt = '0;
      end
    end else if (i_ex_multicycle) begin
      w_ctl        = CtlBubble;
      w_state_nxt  = StMcBusy;
      w_mc_cnt_nxt = McW'(1);
    end else if (i_ex_branch_taken) begin
      // Branch wins over load-use: the ID instruction is on the wrong path anyway.
      w_ctl = CtlBranch;
    end else if (w_load_use) begin
      w_ctl = CtlLoadUse;
    end
  end

  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_state     <= StRun;
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (!w_ctl[7] && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
          o_if_id_flush, o_id_ex_flush, o_ex_mem_flush} = w_ctl;
  assign o_busy      = rst & (r_state == StMcBusy);
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipeline_ctrl;

  localparam int unsigned MC = 4;

  localparam logic [7:0] DEF  = 8'b11111_000;
  localparam logic [7:0] BUB  = 8'b00011_001;
  localparam logic [7:0] LU   = 8'b00111_010;
  localparam logic [7:0] BR   = 8'b11111_110;
  localparam logic [7:0] ZERO = 8'b00000_000;

  logic clk_en = 1'b0;
  logic rst    = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_multicycle, ex_branch_taken;
  logic mem_req, mem_ready;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, busy;
  logic [15:0] stall_cnt;
  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_busy;
  logic [3:0] s_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state: mc_phase 0 = running, k>0 = k-th busy cycle of a multi-cycle op.
  int     m_phase;
  longint m_cnt16, m_cnt4;

  always #5 clk_en = ~clk_en;

  pipeline_ctrl #(.MC_CYCLES(MC), .STALL_CNT_W(16)) u_dut (
    .clk_en(clk_en), .rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_uses_rs1(id_uses_rs1),
    .i_id_uses_rs2(id_uses_rs2), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
    .i_ex_multicycle(ex_multicycle), .i_ex_branch_taken(ex_branch_taken),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en), .o_ex_mem_en(ex_mem_en),
    .o_mem_wb_en(mem_wb_en), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_flush(ex_mem_flush), .o_busy(busy), .o_stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.MC_CYCLES(MC), .STALL_CNT_W(4)) u_dut4 (
    .clk_en(clk_en), .rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_uses_rs1(id_uses_rs1),
    .i_id_uses_rs2(id_uses_rs2), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
    .i_ex_multicycle(ex_multicycle), .i_ex_branch_taken(ex_branch_taken),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_id_ex_en(s_id_ex_en),
    .o_ex_mem_en(s_ex_mem_en), .o_mem_wb_en(s_mem_wb_en), .o_if_id_flush(s_if_id_flush),
    .o_id_ex_flush(s_id_ex_flush), .o_ex_mem_flush(s_ex_mem_flush), .o_busy(s_busy),
    .o_stall_cnt(s_stall_cnt)
  );

  wire [7:0] act  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush};
  wire [7:0] act4 = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                     s_if_id_flush, s_id_ex_flush, s_ex_mem_flush};

  task automatic drive_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    ex_multicycle = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_en);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  function automatic logic [7:0] exp_out();
    logic lu;
    if (!rst) return ZERO;
    if (mem_req && !mem_ready) return ZERO;
    if (m_phase != 0) return (m_phase < int'(MC) - 1) ? BUB : DEF;
    if (ex_multicycle) return BUB;
    if (ex_branch_taken) return BR;
    lu = ex_is_load && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    return lu ? LU : DEF;
  endfunction

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({act, busy, stall_cnt} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b/%b/%0d want all zero", act, busy, stall_cnt);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (act !== DEF || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got %b busy=%b want %b busy=0", act, busy, DEF);
    end
    // Abort a multi-cycle op at mc_cnt == 2.
    tick();
    ex_multicycle = 1'b1;
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_midop_busy: got %b want 1", busy);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({act, busy, stall_cnt} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_midop_outputs: got %b/%b/%0d want all zero", act, busy, stall_cnt);
    end
    ex_multicycle = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (act !== DEF || busy !== 1'b0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_midop_release: got %b busy=%b cnt=%0d want %b busy=0 cnt=0",
               act, busy, stall_cnt, DEF);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    n_vec++;
    if (act !== LU) begin
      n_err++;
      $display("FAIL load_use_rs1: got %b want %b", act, LU);
    end
    tick();
    ex_is_load = 1'b0;
    #1;
    n_vec++;
    if (act !== DEF || stall_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL load_use_after: got %b cnt=%0d want %b cnt=1", act, stall_cnt, DEF);
    end
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    n_vec++;
    if (act !== DEF) begin
      n_err++;
      $display("FAIL load_use_x0: got %b want %b", act, DEF);
    end
    tick();
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
    #1;
    n_vec++;
    if (act !== DEF || stall_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL load_use_unused_rs1: got %b cnt=%0d want %b cnt=1", act, stall_cnt, DEF);
    end
    id_rs2 = 5'd7;
    #1;
    n_vec++;
    if (act !== LU) begin
      n_err++;
      $display("FAIL load_use_rs2: got %b want %b", act, LU);
    end
  endtask

  task automatic test_multicycle();
    logic [7:0] want;
    do_reset();
    ex_multicycle = 1'b1;  // held: ID/EX is frozen, so the input stays up while busy
    for (int c = 0; c < int'(MC); c++) begin
      #1;
      want = (c < int'(MC) - 1) ? BUB : DEF;
      n_vec++;
      if (act !== want || busy !== (c != 0)) begin
        n_err++;
        $display("FAIL multicycle_c%0d: got %b busy=%b want %b busy=%b", c, act, busy, want,
                 c != 0);
      end
      if (c == int'(MC) - 1) ex_multicycle = 1'b0;
      tick();
    end
    n_vec++;
    if (busy !== 1'b0 || act !== DEF || stall_cnt !== 16'(MC - 1)) begin
      n_err++;
      $display("FAIL multicycle_end: got busy=%b %b cnt=%0d want busy=0 %b cnt=%0d",
               busy, act, stall_cnt, DEF, MC - 1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_multicycle = 1'b1;
    for (int c = 0; c < int'(MC); c++) tick();
    #1;
    n_vec++;
    if (act !== BUB || busy !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_reenter: got %b busy=%b want %b busy=0", act, busy, BUB);
    end
    tick();
    n_vec++;
    if (busy !== 1'b1 || stall_cnt !== 16'(MC)) begin
      n_err++;
      $display("FAIL back_to_back_busy: got busy=%b cnt=%0d want busy=1 cnt=%0d",
               busy, stall_cnt, MC);
    end
    ex_multicycle = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    #1;
    n_vec++;
    if (act !== BR) begin
      n_err++;
      $display("FAIL branch_over_load_use: got %b want %b", act, BR);
    end
    tick();
    n_vec++;
    if (stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL branch_no_stall: got %0d want 0", stall_cnt);
    end
    ex_multicycle = 1'b1;
    #1;
    n_vec++;
    if (act !== BUB) begin
      n_err++;
      $display("FAIL branch_with_multicycle: got %b want %b", act, BUB);
    end
  endtask

  task automatic test_mem_wait();
    int busy_cycles;
    do_reset();
    ex_multicycle = 1'b1;
    tick();
    ex_multicycle = 1'b0;
    busy_cycles = 0;
    mem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (act !== ZERO || busy !== 1'b1) begin
        n_err++;
        $display("FAIL mem_wait_c%0d: got %b busy=%b want %b busy=1", c, act, busy, ZERO);
      end
      if (busy) busy_cycles++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_vec++;
    if (act !== BUB) begin
      n_err++;
      $display("FAIL mem_wait_hold_cnt: got %b want %b", act, BUB);
    end
    for (int c = 0; c < 8 && busy; c++) begin
      busy_cycles++;
      tick();
    end
    n_vec++;
    if (busy_cycles != 6 || stall_cnt !== 16'd6) begin
      n_err++;
      $display("FAIL mem_wait_busy_len: got busy=%0d cnt=%0d want busy=6 cnt=6",
               busy_cycles, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    n_vec++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      n_err++;
      $display("FAIL saturation: got w4=%0d w16=%0d want w4=15 w16=20", s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    do_reset();
    m_phase = 0; m_cnt16 = 0; m_cnt4 = 0;
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(99) != 0);
      id_rs1          = 5'($urandom_range(3));
      id_rs2          = 5'($urandom_range(3));
      ex_rd           = 5'($urandom_range(3));
      id_uses_rs1     = 1'($urandom);
      id_uses_rs2     = 1'($urandom);
      ex_is_load      = 1'($urandom);
      ex_multicycle   = ($urandom_range(7) == 0);
      ex_branch_taken = ($urandom_range(4) == 0);
      mem_req         = ($urandom_range(3) == 0);
      mem_ready       = 1'($urandom);
      #1;
      if (!rst) begin
        m_phase = 0; m_cnt16 = 0; m_cnt4 = 0;
      end
      e = exp_out();
      n_vec++;
      if (act !== e || act4 !== e || busy !== (m_phase != 0) || s_busy !== (m_phase != 0)) begin
        n_err++;
        $display("FAIL random_ctl[%0d]: got %b/%b busy=%b want %b busy=%b", i, act, act4,
                 busy, e, m_phase != 0);
      end
      n_vec++;
      if (stall_cnt !== 16'(m_cnt16) || s_stall_cnt !== 4'(m_cnt4)) begin
        n_err++;
        $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, s_stall_cnt,
                 m_cnt16, m_cnt4);
      end
      if (rst) begin
        if (!e[7]) begin
          m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
          m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
        end
        if (!(mem_req && !mem_ready)) begin
          if (m_phase != 0) m_phase = (m_phase == int'(MC) - 1) ? 0 : m_phase + 1;
          else if (ex_multicycle) m_phase = 1;
        end
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_multicycle();
    test_back_to_back();
    test_branch();
    test_mem_wait();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
